// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer:
// opcode encodings, controller states and opcode classification helpers.
package alu_seq_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Y,
        ST_EXEC,
        ST_WB,
        ST_WB_LO,
        ST_WB_HI,
        ST_DONE
    } state_t;

    function automatic logic is_binary(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_wide(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_sel_decoder.sv
// Register-select to one-hot strobe decoder; all outputs low when disabled.
module reg_sel_decoder #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned NUM_OUT = 16
) (
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller sequencing one register-to-register ALU instruction
// over the shared bus datapath (regfile -> Y -> ALU -> Z -> regfile or HI/LO).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 5,
    parameter int unsigned REG_SEL_W = 4,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [REG_SEL_W-1:0] ra_sel,
    input  logic [REG_SEL_W-1:0] rb_sel,
    input  logic [REG_SEL_W-1:0] rc_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [NUM_REGS-1:0]  r_out,
    output logic [NUM_REGS-1:0]  r_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 zlow_out,
    output logic                 zhigh_out,
    output logic                 lo_in,
    output logic                 hi_in,
    output logic [OPCODE_W-1:0]  alu_op
);

    state_t               state, state_nx;
    logic [OPCODE_W-1:0]  op_q;
    logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q;
    logic                 ill_q;

    logic                 in_binary, in_wide, in_unary;
    logic                 q_unary, q_wide;
    logic                 rout_en, rin_en;
    logic [REG_SEL_W-1:0] rout_sel;

    assign in_binary = is_binary(OP_W'(opcode));
    assign in_wide   = is_wide(OP_W'(opcode));
    assign in_unary  = is_unary(OP_W'(opcode));
    assign q_unary   = is_unary(OP_W'(op_q));
    assign q_wide    = is_wide(OP_W'(op_q));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                op_q  <= opcode;
                ra_q  <= ra_sel;
                rb_q  <= rb_sel;
                rc_q  <= rc_sel;
                ill_q <= !(in_binary || in_wide || in_unary);
            end else if (state == ST_DONE) begin
                ill_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (in_binary || in_wide) state_nx = ST_LOAD_Y;
                    else if (in_unary)        state_nx = ST_EXEC;
                    else                      state_nx = ST_DONE;
                end
            end
            ST_LOAD_Y: state_nx = ST_EXEC;
            ST_EXEC:   state_nx = q_wide ? ST_WB_LO : ST_WB;
            ST_WB:     state_nx = ST_DONE;
            ST_WB_LO:  state_nx = ST_WB_HI;
            ST_WB_HI:  state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Moore outputs: everything below depends only on state and captured fields
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        rout_en   = 1'b0;
        rin_en    = 1'b0;
        rout_sel  = ra_q;
        unique case (state)
            ST_IDLE: ;
            ST_LOAD_Y: begin
                busy    = 1'b1;
                rout_en = 1'b1;
                y_in    = 1'b1;
            end
            ST_EXEC: begin
                busy     = 1'b1;
                rout_en  = 1'b1;
                rout_sel = q_unary ? ra_q : rb_q;
                z_in     = 1'b1;
            end
            ST_WB: begin
                busy     = 1'b1;
                zlow_out = 1'b1;
                rin_en   = 1'b1;
            end
            ST_WB_LO: begin
                busy     = 1'b1;
                zlow_out = 1'b1;
                lo_in    = 1'b1;
            end
            ST_WB_HI: begin
                busy      = 1'b1;
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                illegal = ill_q;
            end
            default: ;
        endcase
    end

    assign alu_op = busy ? op_q : '0;

    reg_sel_decoder #(
        .SEL_W   (REG_SEL_W),
        .NUM_OUT (NUM_REGS)
    ) u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (r_out)
    );

    reg_sel_decoder #(
        .SEL_W   (REG_SEL_W),
        .NUM_OUT (NUM_REGS)
    ) u_rin_dec (
        .en     (rin_en),
        .sel    (rc_q),
        .onehot (r_in)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table of per-cycle vectors plus
// hand-written sequences for asynchronous clear and continuous start.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra_sel, rb_sel, rc_sel;
    logic        busy, done, illegal;
    logic [15:0] r_out, r_in;
    logic        y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [4:0]  alu_op;

    int tests  = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(
        .OPCODE_W  (5),
        .REG_SEL_W (4),
        .NUM_REGS  (16)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .ra_sel    (ra_sel),
        .rb_sel    (rb_sel),
        .rc_sel    (rc_sel),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .r_out     (r_out),
        .r_in      (r_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlow_out  (zlow_out),
        .zhigh_out (zhigh_out),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .alu_op    (alu_op)
    );

    // flags order: busy done illegal y_in z_in zlow_out zhigh_out lo_in hi_in
    typedef struct packed {
        logic        st;
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [8:0]  fl;
        logic [4:0]  alu;
        logic [15:0] ro, ri;
    } vec_t;

    function automatic logic [45:0] outs();
        return {busy, done, illegal, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
                alu_op, r_out, r_in};
    endfunction

    function automatic vec_t mk(logic st, logic [4:0] op, logic [3:0] ra, logic [3:0] rb,
                                logic [3:0] rc, logic [8:0] fl, logic [4:0] alu,
                                logic [15:0] ro, logic [15:0] ri);
        vec_t v;
        v.st = st; v.op = op; v.ra = ra; v.rb = rb; v.rc = rc;
        v.fl = fl; v.alu = alu; v.ro = ro; v.ri = ri;
        return v;
    endfunction

    task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic [4:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc);
        start = st; opcode = op; ra_sel = ra; rb_sel = rb; rc_sel = rc;
    endtask

    vec_t vecs[$];

    initial begin
        int done_cnt;
        int ri_seen;
        int waited;
        logic [15:0] ri_got;

        drive(0, 0, 0, 0, 0);
        clear = 1'b1;
        #3;
        check("reset_outputs", outs(), '0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // AND r4 = r2 & r3; opcode changed to OR while busy
        vecs.push_back(mk(1, 5'b00101, 2, 3, 4, 9'b100100000, 5'b00101, 16'h0004, 16'h0000));
        vecs.push_back(mk(0, 5'b00110, 9, 9, 9, 9'b100010000, 5'b00101, 16'h0008, 16'h0000));
        vecs.push_back(mk(0, 5'b00110, 9, 9, 9, 9'b100001000, 5'b00101, 16'h0000, 16'h0010));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b010000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        // MUL r1 * r5 -> HI/LO
        vecs.push_back(mk(1, 5'b01111, 1, 5, 9, 9'b100100000, 5'b01111, 16'h0002, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100010000, 5'b01111, 16'h0020, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100001010, 5'b01111, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100000101, 5'b01111, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b010000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        // NOT r7 = ~r7; start during DONE is ignored
        vecs.push_back(mk(1, 5'b10010, 7, 0, 7, 9'b100010000, 5'b10010, 16'h0080, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100001000, 5'b10010, 16'h0000, 16'h0080));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b010000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 5'b11111, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        // illegal opcodes
        vecs.push_back(mk(1, 5'b11111, 0, 0, 0, 9'b011000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 5'b00000, 3, 3, 3, 9'b011000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        // SUB with ra==rb==rc, then back-to-back NEG after DONE
        vecs.push_back(mk(1, 5'b00100, 6, 6, 6, 9'b100100000, 5'b00100, 16'h0040, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100010000, 5'b00100, 16'h0040, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100001000, 5'b00100, 16'h0000, 16'h0040));
        vecs.push_back(mk(1, 5'b10001, 15, 2, 0, 9'b010000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 5'b10001, 15, 2, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 5'b10001, 15, 2, 0, 9'b100010000, 5'b10001, 16'h8000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b100001000, 5'b10001, 16'h0000, 16'h0001));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b010000000, 5'b00000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 9'b000000000, 5'b00000, 16'h0000, 16'h0000));

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].fl, vecs[i].alu, vecs[i].ro, vecs[i].ri});
        end

        // asynchronous clear during EXEC of ADD r3 = r1 + r2
        drive(1, 5'b00011, 1, 2, 3);
        tick();
        drive(0, 5'b00000, 0, 0, 0);
        tick();
        check("add_exec_before_clear", outs(),
              {9'b100010000, 5'b00011, 16'h0004, 16'h0000});
        #2 clear = 1'b1;
        #1;
        check("clear_immediate", outs(), '0);
        ri_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (r_in != '0) ri_seen++;
        end
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (r_in != '0) ri_seen++;
        end
        check1("no_rin_after_clear", ri_seen, 0);

        drive(1, 5'b00011, 1, 2, 3);
        tick();
        drive(0, 5'b00000, 0, 0, 0);
        waited = 1;
        ri_got = '0;
        while (!done && waited < 10) begin
            tick();
            waited++;
            if (r_in != '0) ri_got = r_in;
        end
        check1("restart_latency", waited, 4);
        check1("restart_writeback", ri_got, 16'h0008);
        tick();

        // start held high: ADD every 5 cycles; OR presented mid-instruction
        drive(1, 5'b00011, 1, 2, 3);
        done_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) opcode = 5'b00110;
            check1($sformatf("held_done_c%0d", k), done, (k % 5 == 4) ? 1 : 0);
            if (k == 3) check1("held_alu_op_first", alu_op, 5'b00011);
            if (k == 7) check1("held_alu_op_second", alu_op, 5'b00110);
            if (done) done_cnt++;
        end
        check1("held_done_count", done_cnt, 3);
        drive(0, 5'b00000, 0, 0, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
